// File: rtl/fp32_vec16_dot.sv
// Pipelined FP32 dot product of two 16-element vectors: one multiply stage, a
// four-level balanced adder tree and an output register (6 clocks, 1/clock).
module fp32_vec16_dot #(
    parameter int N = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] vectorA [0:N-1],
    input  logic [31:0] vectorB [0:N-1],
    output logic [31:0] result
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Round-to-nearest-even on a normalised 24-bit significand, then saturate:
    // exponent overflow gives signed Inf, exponent underflow flushes to signed zero.
    function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e_in,
                                               input logic [23:0] mant, input logic g,
                                               input logic st);
        logic [24:0]       rnd;
        logic signed [9:0] e;
        logic [22:0]       frac;
        logic [31:0]       res;
        rnd  = {1'b0, mant} + {24'd0, g & (st | mant[0])};
        e    = e_in;
        frac = rnd[22:0];
        if (rnd[24]) begin
            e    = e + 10'sd1;
            frac = rnd[23:1];
        end
        if (e >= 10'sd255)
            res = {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            res = {s, 31'd0};
        else
            res = {s, e[7:0], frac};
        return res;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [47:0]       prod;
        logic [23:0]       mant;
        logic              g, st;
        logic signed [9:0] e;
        logic [31:0]       res;
        s      = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e      = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            mant = prod[47:24];
            g    = prod[23];
            st   = |prod[22:0];
            e    = e + 10'sd1;
        end else begin
            mant = prod[46:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            res = QNAN;
        else if (a_inf || b_inf)
            res = {s, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            res = {s, 31'd0};
        else
            res = round_pack(s, e, mant, g, st);
        return res;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic              sl;
        logic [7:0]        el, es, d;
        logic [23:0]       ml, ms;
        logic [26:0]       ml_x, ms_full, ms_x, mask, norm;
        logic [27:0]       sum;
        logic [4:0]        lz;
        logic signed [9:0] e;
        logic [31:0]       res;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        // Larger magnitude first so subtraction never goes negative.
        if (a[30:0] >= b[30:0]) begin
            sl = a[31]; el = a[30:23]; ml = {1'b1, a[22:0]};
            es = b[30:23]; ms = {1'b1, b[22:0]};
        end else begin
            sl = b[31]; el = b[30:23]; ml = {1'b1, b[22:0]};
            es = a[30:23]; ms = {1'b1, a[22:0]};
        end
        d       = el - es;
        ml_x    = {ml, 3'b000};
        ms_full = {ms, 3'b000};
        mask    = 27'd0;
        if (d >= 8'd27) begin
            ms_x = 27'd1;
        end else begin
            mask = (27'd1 << d) - 27'd1;
            ms_x = (ms_full >> d) | {26'd0, |(ms_full & mask)};
        end
        sum = (a[31] ^ b[31]) ? ({1'b0, ml_x} - {1'b0, ms_x})
                              : ({1'b0, ml_x} + {1'b0, ms_x});
        lz = 5'd0;
        for (int i = 0; i <= 26; i++)
            if (sum[i]) lz = 5'(26 - i);
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = $signed({2'b00, el}) + 10'sd1;
        end else begin
            norm = sum[26:0] << lz;
            e    = $signed({2'b00, el}) - $signed({5'd0, lz});
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            res = QNAN;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (a_zero && b_zero)
            res = {a[31] & b[31], 31'd0};
        else if (a_zero)
            res = b;
        else if (b_zero)
            res = a;
        else if (sum == 28'd0)
            res = 32'd0;
        else
            res = round_pack(sl, e, norm[26:3], norm[2], |norm[1:0]);
        return res;
    endfunction

    logic [31:0] prod_p1_d [0:N-1];
    logic [31:0] prod_p1_q [0:N-1];
    logic [31:0] sum_p2_d  [0:N/2-1];
    logic [31:0] sum_p2_q  [0:N/2-1];
    logic [31:0] sum_p3_d  [0:N/4-1];
    logic [31:0] sum_p3_q  [0:N/4-1];
    logic [31:0] sum_p4_d  [0:N/8-1];
    logic [31:0] sum_p4_q  [0:N/8-1];
    logic [31:0] sum_p5_d;
    logic [31:0] sum_p5_q;
    logic [31:0] res_p6_q;

    always_comb begin
        for (int i = 0; i < N; i++)
            prod_p1_d[i] = fp_mul(vectorA[i], vectorB[i]);
        for (int i = 0; i < N/2; i++)
            sum_p2_d[i] = fp_add(prod_p1_q[2*i], prod_p1_q[2*i+1]);
        for (int i = 0; i < N/4; i++)
            sum_p3_d[i] = fp_add(sum_p2_q[2*i], sum_p2_q[2*i+1]);
        for (int i = 0; i < N/8; i++)
            sum_p4_d[i] = fp_add(sum_p3_q[2*i], sum_p3_q[2*i+1]);
        sum_p5_d = fp_add(sum_p4_q[0], sum_p4_q[1]);
    end

    // Stage 1 products, stages 2-5 adder tree levels, stage 6 output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_p1_q <= '{default: 32'd0};
            sum_p2_q  <= '{default: 32'd0};
            sum_p3_q  <= '{default: 32'd0};
            sum_p4_q  <= '{default: 32'd0};
            sum_p5_q  <= 32'd0;
            res_p6_q  <= 32'd0;
        end else begin
            prod_p1_q <= prod_p1_d;
            sum_p2_q  <= sum_p2_d;
            sum_p3_q  <= sum_p3_d;
            sum_p4_q  <= sum_p4_d;
            sum_p5_q  <= sum_p5_d;
            res_p6_q  <= sum_p5_q;
        end
    end

    assign result = res_p6_q;

endmodule

// File: tb/tb_fp32_vec16_dot.sv
// Bench for fp32_vec16_dot: directed and random vectors against a real-arithmetic
// reference that rounds each tree operation to FP32 (RNE, flush-to-zero).
module tb_fp32_vec16_dot;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] va [0:15];
    logic [31:0] vb [0:15];
    logic [31:0] result;

    int          nerr = 0;
    int          nchk = 0;
    logic [31:0] hist [$];

    fp32_vec16_dot dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .vectorA(va),
        .vectorB(vb),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FP32 (finite, subnormals treated as zero) to real.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Real to FP32 with round-to-nearest-even, overflow to Inf, underflow to zero.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] keep;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e    = int'(d[62:52]) - 1023 + 127;
        m    = {1'b1, d[51:0]};
        keep = {1'b0, m[52:29]};
        if (m[28] && ((|m[27:0]) || m[29])) keep = keep + 25'd1;
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], keep[22:0]};
    endfunction

    function automatic bit is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction
    function automatic bit is_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    endfunction
    function automatic bit is_zero(input logic [31:0] f);
        return f[30:23] == 8'd0;
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return QNAN;
        if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return QNAN;
        if (is_inf(a) || is_inf(b)) return {a[31] ^ b[31], 8'hFF, 23'd0};
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) && is_inf(b) && (a[31] != b[31])) return QNAN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] dot_model();
        logic [31:0] t [0:15];
        for (int i = 0; i < 16; i++) t[i] = m_mul(va[i], vb[i]);
        for (int n = 16; n > 1; n = n / 2)
            for (int i = 0; i < n / 2; i++) t[i] = m_add(t[2*i], t[2*i+1]);
        return t[0];
    endfunction

    function automatic logic [31:0] rand_fp();
        int sel;
        sel = $urandom_range(0, 99);
        if (sel == 0) begin
            case ($urandom_range(0, 6))
                0: return 32'h0000_0000;
                1: return 32'h8000_0000;
                2: return 32'h7F80_0000;
                3: return 32'hFF80_0000;
                4: return 32'h7F80_0001;
                5: return 32'h0000_0123;
                default: return 32'h3F80_0000;
            endcase
        end
        if (sel == 1) return $urandom();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom())};
    endfunction

    task automatic rand_vecs();
        for (int i = 0; i < 16; i++) begin
            va[i] = rand_fp();
            vb[i] = rand_fp();
        end
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 16; i++) begin
            va[i] = a;
            vb[i] = b;
        end
    endtask

    task automatic set_t2();
        for (int i = 0; i < 16; i++) begin
            va[i] = r2f(1.0 + real'(i));
            vb[i] = r2f(15.5 - real'(i));
        end
    endtask

    task automatic set_t3();
        for (int i = 0; i < 16; i++) begin
            va[i] = r2f(4.0 - real'(i));
            vb[i] = r2f(real'(i) - 9.96);
        end
    endtask

    // One clock: inputs already stable; result after the edge must equal the
    // model value of the inputs sampled five edges earlier.
    task automatic step(input bit do_rst, input string tag);
        rst_n = !do_rst;
        @(posedge clk);
        #1;
        if (do_rst) begin
            hist.delete();
            repeat (6) hist.push_back(32'd0);
        end else begin
            hist.push_back(dot_model());
        end
        chk(tag, result, hist[hist.size() - 6]);
        @(negedge clk);
    endtask

    task automatic hold_check(input string tag, input logic [31:0] exp);
        repeat (6) step(1'b0, tag);
        chk(tag, result, exp);
    endtask

    initial begin
        longint diff;
        rst_n = 1'b0;
        rand_vecs();
        step(1'b1, "reset");
        chk("reset_zero", result, 32'd0);
        rand_vecs();
        step(1'b1, "reset");
        set_t2();
        repeat (5) begin
            step(1'b0, "drain");
            chk("drain_zero", result, 32'd0);
        end
        step(1'b0, "t2");
        chk("t2_748", result, 32'h443B_0000);

        set_t3();
        repeat (6) step(1'b0, "t3");
        diff = longint'(result) - longint'(32'hC34A_3D71);
        if (diff < 0) diff = -diff;
        chk("t3_ulp", {31'd0, diff <= 4}, 32'd1);

        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) set_t2();
            else set_t3();
            step(1'b0, "thru");
        end

        fill(32'h3F80_0000, 32'h3F80_0000);
        va[0] = 32'h7F80_0001;
        hold_check("nan_in", QNAN);
        fill(32'h3F80_0000, 32'h3F80_0000);
        va[0] = 32'h7F80_0000;
        vb[0] = 32'h0000_0000;
        hold_check("inf_x_0", QNAN);
        fill(32'h0, 32'h0);
        va[0] = 32'h7F80_0000;
        vb[0] = 32'h4000_0000;
        hold_check("inf_x_2", 32'h7F80_0000);
        fill(32'h0, 32'h0);
        va[0] = 32'hFF80_0000;
        vb[0] = 32'h3F80_0000;
        va[1] = 32'h7F80_0000;
        vb[1] = 32'h3F80_0000;
        hold_check("inf_m_inf", QNAN);
        fill(r2f(3.0e38), r2f(3.0e38));
        hold_check("overflow", 32'h7F80_0000);
        for (int i = 0; i < 16; i++) begin
            va[i] = 32'h3F80_0000;
            vb[i] = (i % 2 == 0) ? 32'h4020_0000 : 32'hC020_0000;
        end
        hold_check("cancel", 32'h0000_0000);
        fill(r2f(1.0e-30), r2f(1.0e-30));
        hold_check("underflow", 32'h0000_0000);
        fill(32'h0000_0123, 32'h3F80_0000);
        hold_check("subnormal", 32'h0000_0000);
        fill(32'h8000_0000, 32'h3F80_0000);
        hold_check("neg_zero", 32'h8000_0000);

        repeat (300) begin
            rand_vecs();
            step(1'b0, "rand");
        end

        repeat (3) begin
            rand_vecs();
            step(1'b0, "pre_rst");
        end
        rand_vecs();
        step(1'b1, "mid_rst");
        repeat (10) begin
            rand_vecs();
            step(1'b0, "post_rst");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
